// File: rtl/vga_timing_pkg.sv
// Shared raster types and default 640x480 @ 60 Hz timing for the video pipeline.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned H_TOTAL_DEF =
      H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF =
      V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   blank;
    logic   hs;
    logic   vs;
  } raster_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator (master) to renderers and encoders (slave).
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t     DrawX;
  coord_t     DrawY;
  logic       blank;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hsync, vsync, line_start, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hsync, vsync, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: pixel/line counters with registered sync/blank decode.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT     = H_FRONT_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT     = V_FRONT_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic              vga_clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START   = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END     = HS_START + H_SYNC;
  localparam int unsigned VS_START   = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END     = VS_START + V_SYNC;

  if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
      H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_param_check
    $error("vga_timing_gen: zero timing parameter or total above 1024");
  end

  raster_t    r_q, r_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  // Decode uses the next-state counters so every flag lines up with the coordinates it describes.
  always_comb begin
    r_d           = r_q;
    frame_count_d = frame_count_q;
    r_d.x         = r_q.x + coord_t'(1);
    if (32'(r_q.x) == H_TOTAL - 1) begin
      r_d.x = '0;
      if (32'(r_q.y) == V_TOTAL - 1) begin
        r_d.y         = '0;
        frame_count_d = frame_count_q + 8'd1;
      end else begin
        r_d.y = r_q.y + coord_t'(1);
      end
    end

    r_d.blank = (32'(r_d.x) < H_VISIBLE) && (32'(r_d.y) < V_VISIBLE);
    r_d.hs    = (32'(r_d.x) >= HS_START && 32'(r_d.x) < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    r_d.vs    = (32'(r_d.y) >= VS_START && 32'(r_d.y) < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    line_start_d  = (r_d.x == '0);
    frame_start_d = (r_d.x == '0) && (r_d.y == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_q.x         <= '0;
      r_q.y         <= '0;
      r_q.blank     <= 1'b1;
      r_q.hs        <= ~SYNC_ACTIVE;
      r_q.vs        <= ~SYNC_ACTIVE;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
      frame_count_q <= '0;
    end else begin
      r_q           <= r_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vga.DrawX       = r_q.x;
  assign vga.DrawY       = r_q.y;
  assign vga.blank       = r_q.blank;
  assign vga.hsync       = r_q.hs;
  assign vga.vsync       = r_q.vs;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default and tiny timings checked against an arithmetic raster model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  vga_timing_gen_if vif_d ();
  vga_timing_gen_if vif_s ();

  vga_timing_gen dut_d (
    .vga_clk (vga_clk),
    .reset   (rst_d),
    .vga     (vif_d.master)
  );

  vga_timing_gen #(
    .H_VISIBLE   (8),
    .H_FRONT     (1),
    .H_SYNC      (1),
    .H_BACK      (1),
    .V_VISIBLE   (4),
    .V_FRONT     (1),
    .V_SYNC      (1),
    .V_BACK      (1),
    .SYNC_ACTIVE (1'b1)
  ) dut_s (
    .vga_clk (vga_clk),
    .reset   (rst_s),
    .vga     (vif_s.master)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x, y, blank, hs, vs, ls, fs, fc;
  } exp_t;

  // Position is purely a function of cycles since the last reset edge.
  function automatic exp_t ref_at(input int k, input int hv, input int hf, input int hs,
                                  input int hb, input int vv, input int vf, input int vs,
                                  input int vb, input int act);
    exp_t e;
    int ht, vt, p;
    ht      = hv + hf + hs + hb;
    vt      = vv + vf + vs + vb;
    p       = k % (ht * vt);
    e.x     = p % ht;
    e.y     = p / ht;
    e.fc    = (k / (ht * vt)) % 256;
    e.blank = (e.x < hv && e.y < vv) ? 1 : 0;
    e.hs    = (e.x >= hv + hf && e.x < hv + hf + hs) ? act : 1 - act;
    e.vs    = (e.y >= vv + vf && e.y < vv + vf + vs) ? act : 1 - act;
    e.ls    = (e.x == 0) ? 1 : 0;
    e.fs    = (e.x == 0 && e.y == 0) ? 1 : 0;
    return e;
  endfunction

  function automatic logic [63:0] pack_exp(input exp_t e);
    return {31'd0, 10'(e.x), 10'(e.y), 1'(e.blank), 1'(e.hs), 1'(e.vs), 1'(e.ls), 1'(e.fs),
            8'(e.fc)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference cycle counters: 0 on the cycle showing the reset state.
  int k_d = 0, k_s = 0;
  bit val_d = 1'b0, val_s = 1'b0;

  always @(posedge vga_clk) begin
    if (rst_d) begin
      k_d   <= 0;
      val_d <= 1'b1;
    end else if (val_d) begin
      k_d <= k_d + 1;
    end
    if (rst_s) begin
      k_s   <= 0;
      val_s <= 1'b1;
    end else if (val_s) begin
      k_s <= k_s + 1;
    end
  end

  always @(negedge vga_clk) begin
    if (val_d && errors < 20)
      chk("raster_d {x,y,blank,hs,vs,ls,fs,fc}",
          {31'd0, vif_d.DrawX, vif_d.DrawY, vif_d.blank, vif_d.hsync, vif_d.vsync,
           vif_d.line_start, vif_d.frame_start, vif_d.frame_count},
          pack_exp(ref_at(k_d, H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF,
                          V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF, 0)));
    if (val_s && errors < 20)
      chk("raster_s {x,y,blank,hs,vs,ls,fs,fc}",
          {31'd0, vif_s.DrawX, vif_s.DrawY, vif_s.blank, vif_s.hsync, vif_s.vsync,
           vif_s.line_start, vif_s.frame_start, vif_s.frame_count},
          pack_exp(ref_at(k_s, 8, 1, 1, 1, 4, 1, 1, 1, 1)));
  end

  initial begin
    int hs_cnt, hs_first, blank_fall, vs_cnt, ls_at, fs_at, hs_x;
    bit found;

    repeat (3) @(posedge vga_clk);
    #1;
    rst_d = 1'b0;
    rst_s = 1'b0;

    // Default timing: reset state, then one full line.
    @(negedge vga_clk);
    chk("rst_drawx", 64'(vif_d.DrawX), 64'd0);
    chk("rst_drawy", 64'(vif_d.DrawY), 64'd0);
    chk("rst_blank", 64'(vif_d.blank), 64'd1);
    chk("rst_hsync_vsync", 64'({vif_d.hsync, vif_d.vsync}), 64'd3);
    chk("rst_frame_start", 64'(vif_d.frame_start), 64'd1);
    chk("rst_frame_count", 64'(vif_d.frame_count), 64'd0);
    @(negedge vga_clk);
    chk("drawx_after_release", 64'(vif_d.DrawX), 64'd1);
    hs_cnt = 0;
    hs_first = -1;
    blank_fall = -1;
    for (int i = 2; i < 800; i++) begin
      @(negedge vga_clk);
      if (vif_d.hsync === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(vif_d.DrawX);
      end
      if (vif_d.blank === 1'b0 && blank_fall < 0) blank_fall = int'(vif_d.DrawX);
    end
    chk("blank_fall_x", 64'(blank_fall), 64'd640);
    chk("hsync_first_x", 64'(hs_first), 64'd656);
    chk("hsync_width", 64'(hs_cnt), 64'd96);
    @(negedge vga_clk);
    chk("line_wrap {x,y,ls,fs}",
        64'({vif_d.DrawX, vif_d.DrawY, vif_d.line_start, vif_d.frame_start}),
        64'({10'd0, 10'd1, 1'b1, 1'b0}));

    // Mid-frame reset on the default instance.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge vga_clk);
      if (vif_d.DrawX == 10'd300 && vif_d.DrawY == 10'd2) found = 1'b1;
    end
    chk("reach_300_2", 64'(found), 64'd1);
    rst_d = 1'b1;
    @(negedge vga_clk);
    rst_d = 1'b0;
    chk("mid_reset {x,y,blank,hs,vs,ls,fs,fc}",
        {31'd0, vif_d.DrawX, vif_d.DrawY, vif_d.blank, vif_d.hsync, vif_d.vsync,
         vif_d.line_start, vif_d.frame_start, vif_d.frame_count},
        {31'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0});

    // Random reset pulses on the tiny instance; the model tracks them.
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(1, 150)) @(posedge vga_clk);
      #1 rst_s = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge vga_clk);
      #1 rst_s = 1'b0;
    end

    // Tiny timing: line 11, hsync only at x=9, vsync one line, frame 77, count wrap.
    @(posedge vga_clk);
    #1 rst_s = 1'b1;
    @(posedge vga_clk);
    #1 rst_s = 1'b0;
    hs_cnt = 0;
    hs_x = -1;
    vs_cnt = 0;
    ls_at = -1;
    fs_at = -1;
    for (int i = 0; i <= 77; i++) begin
      @(negedge vga_clk);
      if (i > 0 && vif_s.line_start === 1'b1 && ls_at < 0) ls_at = i;
      if (i > 0 && vif_s.frame_start === 1'b1 && fs_at < 0) fs_at = i;
      if (i < 11 && vif_s.hsync === 1'b1) begin
        hs_cnt++;
        hs_x = int'(vif_s.DrawX);
      end
      if (i < 77 && vif_s.vsync === 1'b1) vs_cnt++;
    end
    chk("s_line_length", 64'(ls_at), 64'd11);
    chk("s_frame_length", 64'(fs_at), 64'd77);
    chk("s_hsync_count", 64'(hs_cnt), 64'd1);
    chk("s_hsync_x", 64'(hs_x), 64'd9);
    chk("s_vsync_cycles", 64'(vs_cnt), 64'd11);
    chk("s_frame_count_1", 64'(vif_s.frame_count), 64'd1);
    repeat (255 * 77 - 77) @(negedge vga_clk);
    chk("s_fc_255 {fs,fc}", 64'({vif_s.frame_start, vif_s.frame_count}), 64'({1'b1, 8'd255}));
    repeat (76) @(negedge vga_clk);
    chk("s_last_pixel {x,y,fs,fc}",
        64'({vif_s.DrawX, vif_s.DrawY, vif_s.frame_start, vif_s.frame_count}),
        64'({10'd10, 10'd6, 1'b0, 8'd255}));
    @(negedge vga_clk);
    chk("s_fc_wrap {x,y,ls,fs,fc}",
        64'({vif_s.DrawX, vif_s.DrawY, vif_s.line_start, vif_s.frame_start,
             vif_s.frame_count}),
        64'({10'd0, 10'd0, 1'b1, 1'b1, 8'd0}));

    repeat (5) @(negedge vga_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster that all sprite and background renderers consume: DrawX/DrawY pixel coordinates, the active-video qualifier `blank`, HSYNC/VSYNC, and per-line/per-frame strobes.
- Sits between the pixel clock source and every renderer and palette stage, and drives the VGA/HDMI encoder sync inputs.
- Default timing is 640x480 @ 60 Hz: 800 pixel clocks per line, 525 lines per frame.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 1'b0, level driven on hsync/vsync during the sync pulse

Ports:
- vga_clk, in, 1, pixel clock; the only clock
- reset, in, 1, synchronous, active-high
- DrawX, out, 10, current horizontal count, 0..H_TOTAL-1
- DrawY, out, 10, current vertical count, 0..V_TOTAL-1
- blank, out, 1, 1 = DrawX/DrawY inside the visible area (renderers output colour only when high)
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- line_start, out, 1, one-cycle pulse when DrawX==0
- frame_start, out, 1, one-cycle pulse when DrawX==0 && DrawY==0
- frame_count, out, 8, frames completed since reset, wraps at 255->0

Behaviour:
- Derived values: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Elaboration fails if either total exceeds 1024 or any parameter is 0.
- Reset is synchronous and active-high, sampled on the posedge of vga_clk. While reset is high, the registered outputs are:
  - DrawX=0, DrawY=0
  - blank=1, hsync=~SYNC_ACTIVE, vsync=~SYNC_ACTIVE
  - line_start=1, frame_start=1, frame_count=0
- The first cycle after reset deasserts presents (0,0) again, then counting proceeds. Asserting reset mid-frame returns to this state on the next edge; no partial-line flush.
- Horizontal counter: increments every cycle; at H_TOTAL-1 it wraps to 0 and the vertical counter steps.
- Vertical counter: increments on each horizontal wrap; at V_TOTAL-1 it wraps to 0 and frame_count increments (modulo 256) in the same cycle.
- All outputs are registered. hsync, vsync, blank and the strobes are decoded from the next-state counter values, so every output describes the DrawX/DrawY visible in the same cycle. Latency from counter to decode is 0.
- blank = (DrawX < H_VISIBLE) && (DrawY < V_VISIBLE).
- hsync = SYNC_ACTIVE while H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC; otherwise ~SYNC_ACTIVE. This holds on every line, including vertical blanking.
- vsync = SYNC_ACTIVE while V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC, for the whole line including its horizontal blanking; otherwise ~SYNC_ACTIVE.
- Wrap-around: on the cycle after (H_TOTAL-1, V_TOTAL-1), the outputs show (0,0), frame_start=1, line_start=1, and frame_count already incremented.
- No back-pressure and no enable input: the block free-runs every cycle.
- Downstream ROM readers index with DrawX/DrawY directly. DrawX/DrawY are never X after reset.

Decomposition:
- Shared package vga_timing_pkg holds:
  - 640x480 default localparams (H_*/V_* values and totals)
  - typedef logic [9:0] coord_t, used for DrawX/DrawY
  - typedef struct packed {coord_t x, y; logic blank, hs, vs;} raster_t, used by later pipeline-delay stages
- No sub-module is needed: the two counters and the decode are small and tightly coupled. Later sprite stages will reuse the package types rather than this module.

Test Plan:
- Reset held 3 cycles, then released → DrawX=0, DrawY=0, blank=1, hsync=vsync=1, frame_start=1, frame_count=0; DrawX=1 on the next cycle.
- Run one line → blank falls when DrawX=640; hsync=0 exactly for DrawX 656..751 (96 cycles); DrawX wraps 799→0 with DrawY 0→1 and line_start=1.
- Run one frame → blank=0 for all of DrawY 480..524; vsync=0 exactly for DrawY 490..491 (1600 cycles); next frame_start arrives 420000 cycles after the first; frame_count=1.
- Run 256 frames → frame_count wraps 255→0 coincident with frame_start.
- Assert reset for 1 cycle at DrawX=300, DrawY=200 → next cycle shows (0,0), frame_count=0, sync levels inactive, strobes high.
- Instantiate with H_VISIBLE=8, H_FRONT=H_SYNC=H_BACK=1, V_VISIBLE=4, V_FRONT=V_SYNC=V_BACK=1, SYNC_ACTIVE=1 → hsync=1 only at DrawX=9; line length 11; frame length 77 cycles.
